// File: rtl/pipe_stage_elastic_if.sv
// pipe_stage_elastic_if: valid/ready handshake bundle between two pipeline stages
//   master: upstream payload + downstream ready (driver side)
//   slave : the elastic stage itself
interface pipe_stage_elastic_if #(
    parameter int WIDTH = 32
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] in_data_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] out_data_o;
    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o
    );
    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o
    );
endinterface

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: DEPTH-entry in-order elastic stage register with flush and stall/bubble counters
//   clk, rst      : clock, async active-high reset
//   flush_i       : synchronous flush, drops all entries
//   bus           : in_valid/in_ready/in_data upstream, out_valid/out_ready/out_data downstream
//   count_o       : occupied entries
//   stall_cnt_o   : saturating count of cycles head valid but not consumed
//   bubble_cnt_o  : saturating count of cycles downstream ready but stage empty
module pipe_stage_elastic #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    pipe_stage_elastic_if.slave        bus,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [CNT_W-1:0]           stall_cnt_o,
    output logic [CNT_W-1:0]           bubble_cnt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d;
    logic             push, pop;

    // ready looks only at occupancy, so a pop never frees a slot in the same cycle
    assign bus.in_ready_o  = count_q != CW'(DEPTH);
    assign bus.out_valid_o = count_q != '0;
    assign bus.out_data_o  = mem_q[rd_ptr_q];
    assign count_o         = count_q;
    assign stall_cnt_o     = stall_q;
    assign bubble_cnt_o    = bubble_q;

    always_comb begin
        push     = bus.in_valid_i & bus.in_ready_o & ~flush_i;
        pop      = bus.out_valid_o & bus.out_ready_i & ~flush_i;
        rd_ptr_d = flush_i ? '0 : rd_ptr_q + PW'(pop);
        wr_ptr_d = flush_i ? '0 : wr_ptr_q + PW'(push);
        count_d  = flush_i ? '0 : count_q + CW'(push) - CW'(pop);
        // counters see pre-edge handshake state, flush or not
        stall_d  = (bus.out_valid_o & ~bus.out_ready_i & ~&stall_q) ? stall_q + 1'b1 : stall_q;
        bubble_d = (~bus.out_valid_o & bus.out_ready_i & ~&bubble_q) ? bubble_q + 1'b1 : bubble_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= bus.in_data_i;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: directed self-checking bench for pipe_stage_elastic
module tb_pipe_stage_elastic;
    logic       clk, rst, flush_i;
    logic [1:0] count_o;
    logic [7:0] stall_cnt_o, bubble_cnt_o;
    int         total, bad;

    pipe_stage_elastic_if #(.WIDTH(32)) bus();

    pipe_stage_elastic #(.WIDTH(32), .DEPTH(2), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .bus          (bus.slave),
        .count_o      (count_o),
        .stall_cnt_o  (stall_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
        bus.in_valid_i  = v;
        bus.in_data_i   = d;
        bus.out_ready_i = r;
        flush_i         = f;
    endtask

    initial begin
        int i, k, n;
        logic [31:0] exp_q [10];
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(0, 0, 0, 0);
        cyc();
        chk("rst_valid", bus.out_valid_o, 0);
        chk("rst_ready", bus.in_ready_o, 1);
        chk("rst_count", count_o, 0);
        chk("rst_data", bus.out_data_o, 0);
        chk("rst_stall", stall_cnt_o, 0);
        rst = 1'b0;
        drive(0, 0, 1, 0);
        repeat (5) cyc();
        chk("idle_bubble", bubble_cnt_o, 5);
        chk("idle_stall", stall_cnt_o, 0);
        chk("idle_valid", bus.out_valid_o, 0);
        chk("idle_ready", bus.in_ready_o, 1);
        drive(1, 32'h13, 1, 0);
        cyc();
        chk("lat_valid", bus.out_valid_o, 1);
        chk("lat_data", bus.out_data_o, 32'h13);
        drive(0, 0, 1, 0);
        cyc();
        chk("lat_drain", count_o, 0);
        chk("lat_bubble", bubble_cnt_o, 6);
        drive(1, 32'hAAAA_0001, 0, 0);
        cyc();
        drive(1, 32'hAAAA_0002, 0, 0);
        cyc();
        chk("full_count", count_o, 2);
        chk("full_ready", bus.in_ready_o, 0);
        chk("full_stall1", stall_cnt_o, 1);
        drive(1, 32'hAAAA_0003, 0, 0);
        cyc();
        chk("full_stall2", stall_cnt_o, 2);
        chk("full_count2", count_o, 2);
        chk("full_head", bus.out_data_o, 32'hAAAA_0001);
        drive(1, 32'hAAAA_0003, 1, 0);
        cyc();
        chk("popfull_count", count_o, 1);
        chk("popfull_ready", bus.in_ready_o, 1);
        chk("popfull_head", bus.out_data_o, 32'hAAAA_0002);
        chk("popfull_stall", stall_cnt_o, 2);
        drive(0, 0, 1, 0);
        cyc();
        chk("drain_count", count_o, 0);
        drive(1, 32'h11, 0, 0);
        cyc();
        drive(1, 32'h22, 0, 0);
        cyc();
        chk("pre_flush_count", count_o, 2);
        drive(1, 32'hDEAD_BEEF, 1, 1);
        cyc();
        chk("flush_count", count_o, 0);
        chk("flush_valid", bus.out_valid_o, 0);
        chk("flush_stall", stall_cnt_o, 3);
        chk("flush_bubble", bubble_cnt_o, 6);
        drive(1, 32'h55, 0, 0);
        cyc();
        drive(1, 32'h66, 0, 1);
        cyc();
        chk("flush_push_count", count_o, 0);
        chk("flush_cycle_stall", stall_cnt_o, 4);
        drive(1, 32'h99, 0, 0);
        cyc();
        chk("post_flush_count", count_o, 1);
        chk("post_flush_data", bus.out_data_o, 32'h99);
        drive(0, 0, 1, 0);
        cyc();
        chk("post_flush_drain", count_o, 0);
        for (int j = 0; j < 10; j++) exp_q[j] = 32'hC0 + j;
        i = 0;
        k = 0;
        n = 0;
        while (k < 10 && n < 100) begin
            drive(i < 10, 32'hC0 + i, n[0], 0);
            if (bus.out_valid_o && bus.out_ready_i) begin
                chk("stream_data", bus.out_data_o, exp_q[k]);
                k++;
            end
            if (bus.in_valid_i && bus.in_ready_o) i++;
            cyc();
            n++;
        end
        chk("stream_done", k, 10);
        drive(1, 32'h1, 0, 0);
        cyc();
        drive(0, 0, 0, 0);
        repeat (300) cyc();
        chk("stall_sat", stall_cnt_o, 255);
        chk("sat_valid", bus.out_valid_o, 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", bus.out_valid_o, 0);
        chk("arst_count", count_o, 0);
        chk("arst_stall", stall_cnt_o, 0);
        chk("arst_ready", bus.in_ready_o, 1);
        chk("arst_data", bus.out_data_o, 0);
        rst = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised elastic pipeline-stage register that replaces the fixed load=1, flush=0 stage registers between IF/ID/EX/MEM/WB.
- Adds a valid/ready handshake, a DEPTH-entry in-order buffer that absorbs memory-response stalls, and a synchronous flush for branch redirect.
- Keeps saturating stall and bubble performance counters.
- One instance sits between each pair of pipeline stages; the payload is the packed stage bundle (PC, instr, ctrl word, operands, immediates, rd).

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- DEPTH, 2, buffer entries; power of two, >=2.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush_i  input  1  synchronous flush; discards all buffered entries.
- in_valid_i  input  1  upstream stage presents a valid payload.
- in_ready_o  output  1  buffer can accept a payload this cycle.
- in_data_i  input  WIDTH  upstream payload.
- out_valid_o  output  1  head entry is valid.
- out_ready_i  input  1  downstream stage consumes the head this cycle.
- out_data_o  output  WIDTH  head payload.
- count_o  output  $clog2(DEPTH+1)  number of occupied entries.
- stall_cnt_o  output  CNT_W  cycles with out_valid_o=1 and out_ready_i=0.
- bubble_cnt_o  output  CNT_W  cycles with out_valid_o=0 and out_ready_i=1.

Behaviour:
- Reset (async, rst=1):
  - count=0; read and write pointers=0; all storage=0.
  - out_valid_o=0, out_data_o=0, in_ready_o=1.
  - stall_cnt_o=0, bubble_cnt_o=0.
  - Reset asserted mid-transfer drops every entry immediately, without waiting for a clock edge.
- Storage: circular buffer of DEPTH x WIDTH; pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Handshake outputs:
  - in_ready_o = (count != DEPTH). It depends on registered state only; there is no combinational path from out_ready_i.
  - out_valid_o = (count != 0).
  - out_data_o = storage[rd_ptr], combinational read of registered state.
- Push = in_valid_i & in_ready_o & ~flush_i: write at wr_ptr, then wr_ptr+1.
- Pop = out_valid_o & out_ready_i & ~flush_i: rd_ptr+1.
- Count update: push only +1; pop only -1; push and pop together leaves count unchanged, and both pointers advance.
- Latency: a push into an empty buffer appears on out_valid_o/out_data_o on the next cycle. There is no same-cycle bypass.
- Full: in_ready_o=0. A pop in the same cycle does not enable a push; ready reopens on the following cycle.
- Empty: out_valid_o=0. out_ready_i is ignored apart from bubble counting.
- Flush (flush_i=1 at the edge):
  - count, rd_ptr and wr_ptr all go to 0.
  - A push or pop presented in the flush cycle is discarded and not counted.
  - Storage contents are left unchanged.
  - Flush has priority over push and pop.
- Payload is never modified or reordered; order is strict FIFO.
- Counters:
  - stall_cnt_o increments when out_valid_o & ~out_ready_i.
  - bubble_cnt_o increments when ~out_valid_o & out_ready_i.
  - Both saturate at 2^CNT_W-1.
  - Both are cleared only by rst, not by flush_i.
  - Both are evaluated on pre-edge values, including in the flush cycle.
- All arithmetic is unsigned; pointer wrap is modulo DEPTH.

Test Plan (WIDTH=32, DEPTH=2, CNT_W=8):
- Reset, then idle with out_ready_i=1 for 5 cycles -> out_valid_o=0, in_ready_o=1, count_o=0, bubble_cnt_o=5, stall_cnt_o=0.
- Push 0x0000_0013 with out_ready_i=1 -> on the next cycle out_valid_o=1 and out_data_o=0x0000_0013; the cycle after, count_o=0.
- Hold out_ready_i=0 and push 0xAAAA_0001, then 0xAAAA_0002 -> count_o=2, in_ready_o=0. A third push of 0xAAAA_0003 is ignored. stall_cnt_o increments each cycle starting the cycle after the first push. After releasing out_ready_i, the outputs are 0xAAAA_0001 then 0xAAAA_0002, and 0xAAAA_0003 never appears.
- Full buffer with simultaneous pop and push attempt -> pop accepted, push rejected; count_o goes 2->1; in_ready_o=1 on the next cycle.
- Buffer holds 2 entries; assert flush_i together with in_valid_i=1 (0xDEAD_BEEF) and out_ready_i=1 -> next cycle count_o=0, out_valid_o=0; 0xDEAD_BEEF is never output; counters are not cleared.
- Stream 10 payloads with out_ready_i toggling every cycle -> all 10 are output in order across pointer wrap.
- Hold a stall for 300 cycles -> stall_cnt_o saturates at 255.
- Assert rst asynchronously mid-stream -> outputs return to their reset values before the next clk edge.
